// File: rtl/eth_rx_axis_packer_if.sv
// AXI-Stream bus carrying packed receive words from the packer to the packet filter.
// Latency: none (wires only). Backpressure: slave drops tready, master holds the beat stable.
// Signals: tdata/tkeep/tvalid/tlast/tuser driven by the master, tready driven by the slave.
interface eth_rx_axis_packer_if #(
  parameter int DATA_W = 32
);
  localparam int KEEP_W = DATA_W / 8;

  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tvalid;
  logic              tlast;
  logic              tuser;
  logic              tready;

  modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/eth_rx_axis_packer.sv
// GMII receive front end: strips preamble/SFD, packs bytes MSB-first into AXIS words, flags bad frames.
// Latency: a word is pushed when the byte after it arrives (or at rx_dv fall); FIFO is fall-through.
// Backpressure: absorbed by the FIFO; when it runs out mid-frame the frame is cut (tuser=1) and dropped.
// Ports: clk_i/a_rst_i (async active-high), gmii_rxd_i/gmii_rx_dv_i/gmii_rx_er_i in,
//   m_axis (AXIS master), overflow_o (sticky), frame_done_o (pulse on tlast push).
// Build option: define ETH_RX_FCS_STRIP_EN to drop the trailing 4 FCS bytes of every frame.
module eth_rx_axis_packer #(
  parameter int STREAM_DATA_WIDTH = 32,
  parameter int FIFO_DEPTH        = 16
) (
  input  logic                        clk_i,
  input  logic                        a_rst_i,
  input  logic [7:0]                  gmii_rxd_i,
  input  logic                        gmii_rx_dv_i,
  input  logic                        gmii_rx_er_i,
  eth_rx_axis_packer_if.master        m_axis,
  output logic                        overflow_o,
  output logic                        frame_done_o
);
  localparam int KEEP_W = STREAM_DATA_WIDTH / 8;
  localparam int CW     = $clog2(KEEP_W) + 1;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_FULL = CW'(KEEP_W);
  // Mid-frame pushes must leave one slot free so the closing beat always fits.
  localparam logic [AW:0] OCC_FWD_LIM = (AW+1)'(FIFO_DEPTH - 2);
  localparam logic [AW:0] OCC_FULL    = (AW+1)'(FIFO_DEPTH);
  localparam logic [7:0]  PRE_BYTE    = 8'h55;
  localparam logic [7:0]  SFD_BYTE    = 8'hD5;

  typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_DATA, S_DROP} state_t;

  typedef struct packed {
    logic [STREAM_DATA_WIDTH-1:0] dat;
    logic [KEEP_W-1:0]            keep;
    logic                         last;
    logic                         user;
  } beat_t;

  state_t                       state_q, state_d;
  logic [STREAM_DATA_WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic                         err_q, err_d;
  logic                         ovf_q, ovf_d;
  logic                         in_vld;
  logic [7:0]                   in_byte;
  logic [KEEP_W-1:0]            keep_tail;

  beat_t                        mem_q [FIFO_DEPTH];
  logic [AW-1:0]                wr_ptr_q, rd_ptr_q;
  logic [AW:0]                  occ_q, occ_eff;
  logic                         push, pop;
  beat_t                        push_beat, head;

`ifdef ETH_RX_FCS_STRIP_EN
  // Four-byte delay line: whatever is still in it at rx_dv fall is the FCS.
  logic [31:0] dly_q, dly_d;
  logic [2:0]  dly_cnt_q, dly_cnt_d;
`endif

  assign pop       = m_axis.tvalid && m_axis.tready;
  assign occ_eff   = occ_q - (AW+1)'(pop);
  assign keep_tail = ~({KEEP_W{1'b1}} >> cnt_q);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    ovf_d     = ovf_q;
    push      = 1'b0;
    push_beat = '0;
    in_vld    = 1'b0;
    in_byte   = gmii_rxd_i;
`ifdef ETH_RX_FCS_STRIP_EN
    dly_d     = dly_q;
    dly_cnt_d = dly_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (gmii_rx_dv_i) begin
          if (gmii_rxd_i == PRE_BYTE)      state_d = S_PREAMBLE;
          else if (gmii_rxd_i == SFD_BYTE) state_d = S_DATA;
          else                             state_d = S_DROP;
        end
      end
      S_PREAMBLE: begin
        if (!gmii_rx_dv_i)                 state_d = S_IDLE;
        else if (gmii_rx_er_i)             state_d = S_DROP;
        else if (gmii_rxd_i == SFD_BYTE)   state_d = S_DATA;
        else if (gmii_rxd_i != PRE_BYTE)   state_d = S_DROP;
      end
      S_DATA: begin
        if (gmii_rx_dv_i) begin
          if (gmii_rx_er_i) err_d = 1'b1;
`ifdef ETH_RX_FCS_STRIP_EN
          dly_d = {dly_q[23:0], gmii_rxd_i};
          if (dly_cnt_q == 3'd4) begin
            in_vld  = 1'b1;
            in_byte = dly_q[31:24];
          end else begin
            dly_cnt_d = dly_cnt_q + 3'd1;
          end
`else
          in_vld = 1'b1;
`endif
          if (in_vld) begin
            if (cnt_q != CNT_FULL) begin
              acc_d = acc_q | ({in_byte, {(STREAM_DATA_WIDTH-8){1'b0}}} >> {cnt_q, 3'b000});
              cnt_d = cnt_q + CW'(1);
            end else if (occ_eff < OCC_FWD_LIM) begin
              push      = 1'b1;
              push_beat = {acc_q, {KEEP_W{1'b1}}, 1'b0, 1'b0};
              acc_d     = {in_byte, {(STREAM_DATA_WIDTH-8){1'b0}}};
              cnt_d     = CW'(1);
            end else begin
              // Out of room: close the frame here as errored and discard the rest.
              push      = (occ_eff != OCC_FULL);
              push_beat = {acc_q, {KEEP_W{1'b1}}, 1'b1, 1'b1};
              ovf_d     = 1'b1;
              state_d   = S_DROP;
              acc_d     = '0;
              cnt_d     = '0;
              err_d     = 1'b0;
`ifdef ETH_RX_FCS_STRIP_EN
              dly_d     = '0;
              dly_cnt_d = '0;
`endif
            end
          end
        end else begin
          if (cnt_q != '0) begin
            if (occ_eff != OCC_FULL) begin
              push      = 1'b1;
              push_beat = {acc_q, keep_tail, 1'b1, err_q};
            end else begin
              ovf_d = 1'b1;
            end
          end
          state_d = S_IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
`ifdef ETH_RX_FCS_STRIP_EN
          dly_d     = '0;
          dly_cnt_d = '0;
`endif
        end
      end
      S_DROP: begin
        if (!gmii_rx_dv_i) state_d = S_IDLE;
      end
      default: state_d = S_DROP;
    endcase
  end

  always_ff @(posedge clk_i or posedge a_rst_i) begin
    if (a_rst_i) begin
      state_q   <= S_DROP;
      acc_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      ovf_q     <= 1'b0;
`ifdef ETH_RX_FCS_STRIP_EN
      dly_q     <= '0;
      dly_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      ovf_q     <= ovf_d;
`ifdef ETH_RX_FCS_STRIP_EN
      dly_q     <= dly_d;
      dly_cnt_q <= dly_cnt_d;
`endif
    end
  end

  always_ff @(posedge clk_i or posedge a_rst_i) begin
    if (a_rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      occ_q <= occ_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // Storage needs no reset; outputs are gated by tvalid.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= push_beat;
  end

  assign head          = mem_q[rd_ptr_q];
  assign m_axis.tvalid = (occ_q != '0);
  assign m_axis.tdata  = m_axis.tvalid ? head.dat  : '0;
  assign m_axis.tkeep  = m_axis.tvalid ? head.keep : '0;
  assign m_axis.tlast  = m_axis.tvalid & head.last;
  assign m_axis.tuser  = m_axis.tvalid & head.user;
  assign overflow_o    = ovf_q;
  assign frame_done_o  = push & push_beat.last;
endmodule

// File: tb/tb_eth_rx_axis_packer.sv
// Scoreboard bench for eth_rx_axis_packer: a byte-level model queues expected beats per frame,
// a monitor pops and compares every accepted AXIS beat.
module tb_eth_rx_axis_packer;
  localparam int DEPTH = 16;
  localparam int BIG   = 1000;
`ifdef ETH_RX_FCS_STRIP_EN
  localparam int STRIP = 4;
`else
  localparam int STRIP = 0;
`endif

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    logic        u;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rxd;
  logic       dv;
  logic       er;
  logic       overflow;
  logic       frame_done;

  exp_t       exp_q[$];
  logic [7:0] pay_q[$];
  int         n_chk = 0;
  int         n_err = 0;
  int         fd_exp = 0;
  int         fd_seen = 0;
  logic       ovf_exp = 1'b0;

  eth_rx_axis_packer_if axis ();

  eth_rx_axis_packer #(.STREAM_DATA_WIDTH(32), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i        (clk),
    .a_rst_i      (rst),
    .gmii_rxd_i   (rxd),
    .gmii_rx_dv_i (dv),
    .gmii_rx_er_i (er),
    .m_axis       (axis),
    .overflow_o   (overflow),
    .frame_done_o (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] b, input logic v, input logic e);
    @(negedge clk);
    rxd = b;
    dv  = v;
    er  = e;
  endtask

  task automatic fill(input int n, input logic [7:0] first);
    pay_q.delete();
    for (int i = 0; i < n; i++) pay_q.push_back(first + 8'(i));
  endtask

  // cap = number of beats the FIFO can hold for this frame before the cut (BIG when draining).
  task automatic model_frame(input int er_idx, input int cap);
    int n, i, nb, w;
    exp_t e;
    n = pay_q.size() - STRIP;
    if (n < 0) n = 0;
    i = 0;
    nb = 0;
    while (i < n) begin
      w = (n - i > 4) ? 4 : n - i;
      e.d = '0;
      for (int j = 0; j < w; j++) e.d[8*(3-j) +: 8] = pay_q[i+j];
      if (i + w < n) begin
        e.k = 4'hF;
        if (nb == cap - 1) begin
          e.l = 1'b1;
          e.u = 1'b1;
          exp_q.push_back(e);
          fd_exp++;
          ovf_exp = 1'b1;
          break;
        end
        e.l = 1'b0;
        e.u = 1'b0;
      end else begin
        case (w)
          1:       e.k = 4'h8;
          2:       e.k = 4'hC;
          3:       e.k = 4'hE;
          default: e.k = 4'hF;
        endcase
        e.l = 1'b1;
        e.u = (er_idx >= 0);
        fd_exp++;
      end
      exp_q.push_back(e);
      nb++;
      i += w;
    end
  endtask

  task automatic send_frame(input int er_idx, input int cap);
    model_frame(er_idx, cap);
    repeat (7) drive(8'h55, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
    foreach (pay_q[i]) drive(pay_q[i], 1'b1, i == er_idx);
    repeat (3) drive(8'h00, 1'b0, 1'b0);
  endtask

  task automatic wait_drain(input string tag);
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || axis.tvalid) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    repeat (2) @(negedge clk);
    check_val({tag, "_drain"}, exp_q.size(), 0);
    check_val({tag, "_fdone"}, fd_seen, fd_exp);
  endtask

  // Monitor: samples 1 time unit before the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (!rst) begin
        if (frame_done) fd_seen++;
        if (axis.tvalid && axis.tready) begin
          check_val("beat_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_val("tdata", axis.tdata, e.d);
            check_val("tkeep", axis.tkeep, e.k);
            check_val("tlast", axis.tlast, e.l);
            if (e.l) check_val("tuser", axis.tuser, e.u);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1);
  end

  initial begin
    rxd = 8'h00;
    dv  = 1'b0;
    er  = 1'b0;
    axis.tready = 1'b1;
    #1 rst = 1'b1;
    #20;
    check_val("rst_tvalid", axis.tvalid, 0);
    check_val("rst_tdata", axis.tdata, 0);
    check_val("rst_tkeep", axis.tkeep, 0);
    check_val("rst_tlast", axis.tlast, 0);
    check_val("rst_tuser", axis.tuser, 0);
    check_val("rst_overflow", overflow, 0);
    check_val("rst_frame_done", frame_done, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    fill(8, 8'h01);  send_frame(-1, BIG); wait_drain("t1_8byte");
    fill(6, 8'h01);  send_frame(-1, BIG); wait_drain("t2_6byte");
    fill(12, 8'h10); send_frame(2, BIG);  wait_drain("t3_rxer");
    check_val("t3_overflow", overflow, ovf_exp);

    // Bad preamble byte: the whole frame must vanish.
    drive(8'h55, 1'b1, 1'b0);
    drive(8'h55, 1'b1, 1'b0);
    drive(8'h3C, 1'b1, 1'b0);
    drive(8'h55, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) drive(8'(i + 1), 1'b1, 1'b0);
    repeat (3) drive(8'h00, 1'b0, 1'b0);
    wait_drain("t5_badpre");
    fill(10, 8'h20); send_frame(-1, BIG); wait_drain("t5_after_bad");

    fill(60, 8'h40);
    pay_q.push_back(8'hDE);
    pay_q.push_back(8'hAD);
    pay_q.push_back(8'hBE);
    pay_q.push_back(8'hEF);
    send_frame(-1, BIG); wait_drain("t6_64byte");
    fill(3, 8'h70); send_frame(-1, BIG); wait_drain("t6_3byte");

    // Overflow: downstream stalled, long frame.
    axis.tready = 1'b0;
    fill(100, 8'h80);
    send_frame(-1, DEPTH - 1);
    repeat (4) @(negedge clk);
    check_val("t4_overflow_set", overflow, ovf_exp);
    check_val("t4_fdone_stalled", fd_seen, fd_exp);
    axis.tready = 1'b1;
    wait_drain("t4_cut");
    fill(16, 8'hA0); send_frame(-1, BIG); wait_drain("t4_next");
    check_val("t4_overflow_sticky", overflow, ovf_exp);

    // Reset mid-frame with rx_dv held high: the tail must be ignored.
    repeat (7) drive(8'h55, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
    drive(8'h11, 1'b1, 1'b0);
    drive(8'h22, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    rxd = 8'h33;
    ovf_exp = 1'b0;
    drive(8'h44, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    rxd = 8'h55;
    drive(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) drive(8'(8'hE0 + i), 1'b1, 1'b0);
    repeat (3) drive(8'h00, 1'b0, 1'b0);
    wait_drain("t5_rst_mid");
    check_val("t5_overflow_clr", overflow, ovf_exp);
    fill(9, 8'hC0); send_frame(-1, BIG); wait_drain("t5_after_rst");

    check_val("leftover", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
